can_tx_bit_stuffer: RTL

Transmit-side bit stuffer for the CAN controller. It takes the unstuffed frame bitstream one bit at a time through a valid/ready handshake and drives the serial `tx` line, one bit per `bit_tick`. After `STUFF_LEN` consecutive equal bits it inserts a complementary stuff bit. It is the transmit counterpart of the receive path's edge detection and destuffing, and sits between the TX frame sequencer and the bus driver.

---
 rtl/can_tx_bit_stuffer.sv | 99 +++++++++
 1 files changed

// File: rtl/can_tx_bit_stuffer.sv
// CAN transmit bit stuffer: drains a one-bit holding buffer onto tx once per bit_tick,
// inserting a complementary bit after STUFF_LEN equal bits while stuffing is enabled.
module can_tx_bit_stuffer #(
   parameter int STUFF_LEN = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic bit_tick,
   input  logic stuff_en,
   input  logic din_valid,
   input  logic din,
   output logic din_ready,
   output logic tx,
   output logic stuff_bit,
   output logic idle
);
   localparam int CW = $clog2(STUFF_LEN + 1);
   localparam logic [CW-1:0] RUN_MAX = CW'(STUFF_LEN);

   logic          buf_bit_q, buf_bit_d;
   logic          buf_valid_q, buf_valid_d;
   logic          last_q, last_d;
   logic          tx_q, tx_d;
   logic          stuff_q, stuff_d;
   logic          idle_q, idle_d;
   logic [CW-1:0] run_q, run_d;
   logic          stuff_pend;

   assign stuff_pend = stuff_en && (run_q == RUN_MAX);
   assign din_ready  = !buf_valid_q;
   assign tx         = tx_q;
   assign stuff_bit  = stuff_q;
   assign idle       = idle_q;

   always_comb begin
      buf_bit_d   = buf_bit_q;
      buf_valid_d = buf_valid_q;
      last_d      = last_q;
      tx_d        = tx_q;
      stuff_d     = stuff_q;
      idle_d      = idle_q;
      run_d       = run_q;

      // A load needs an empty buffer and a consume needs a full one, so they never collide.
      if (din_valid && !buf_valid_q) begin
         buf_bit_d   = din;
         buf_valid_d = 1'b1;
      end

      if (bit_tick) begin
         if (stuff_pend) begin
            // The stuff bit itself opens the next run.
            tx_d    = ~last_q;
            stuff_d = 1'b1;
            idle_d  = 1'b0;
            last_d  = ~last_q;
            run_d   = CW'(1);
         end else if (buf_valid_q) begin
            tx_d        = buf_bit_q;
            stuff_d     = 1'b0;
            idle_d      = 1'b0;
            buf_valid_d = 1'b0;
            last_d      = buf_bit_q;
            if (!stuff_en)
               run_d = '0;
            else if (buf_bit_q == last_q && run_q != '0)
               run_d = run_q + CW'(1);
            else
               run_d = CW'(1);
         end else begin
            tx_d    = 1'b1;
            stuff_d = 1'b0;
            idle_d  = 1'b1;
            run_d   = '0;
            last_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_bit_q   <= 1'b0;
         buf_valid_q <= 1'b0;
         last_q      <= 1'b1;
         tx_q        <= 1'b1;
         stuff_q     <= 1'b0;
         idle_q      <= 1'b1;
         run_q       <= '0;
      end else begin
         buf_bit_q   <= buf_bit_d;
         buf_valid_q <= buf_valid_d;
         last_q      <= last_d;
         tx_q        <= tx_d;
         stuff_q     <= stuff_d;
         idle_q      <= idle_d;
         run_q       <= run_d;
      end
   end
endmodule
